rx_fir_filter: RTL and testbench
================================

# rx_fir_filter

Two-channel, 63-tap, symmetric, linear-phase receive FIR filter. It sits after the receive ADC/decimation front end and takes one 16-bit signed sample per `nd` strobe; the sample rate is typically clk/64. Each channel (A, B) has its own delay line and shares one coefficient set. The block produces one 18-bit filtered output per accepted sample, flagged by `rdy` and tagged with the channel it belongs to.

## Interface
- `COEFS`, default all 32 entries = 16'sd512: packed 32×16-bit signed Q1.15 unique coefficients. h[k] for k=0..31 sits at bits [16k+15:16k]. h[31] is the centre tap, and tap j uses h[min(j, 62−j)].
- `OUT_SHIFT`, default 15: arithmetic right shift applied to the full-precision sum before saturation.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `nd`  in  1  new-data strobe; `din`/`chan_in` are valid in this cycle.
- `din`  in  16  signed two's-complement sample.
- `chan_in`  in  1  channel select, 1 = channel A, 0 = channel B.
- `rdy`  out  1  one-cycle pulse; `dout`/`chan_out` are valid.
- `dout`  out  18  signed filtered sample.
- `chan_out`  out  1  channel of the current `dout`.

## Operation
- **Delay line write.** On `nd`, `din` shifts into the delay line of the selected channel: x[0] ← din, x[j] ← x[j−1] for j=1..62. The other channel's line is untouched.
- **Pre-add.** Form 32 sums from the written channel's post-shift line: s[k] = x[k] + x[62−k] for k=0..30, and s[31] = x[31]. Width is 17 bits signed.
- **Multiply.** p[k] = s[k] × h[k], 33 bits signed.
- **Adder tree.** Levels of 16, 8, 4, 2, then 1. Each level grows the width by one bit, giving a 38-bit final sum. There is no intermediate truncation.
- **Output scaling.** y = sum >>> OUT_SHIFT (arithmetic shift, floor). Saturate y to [−131072, 131071] to form `dout`.
- **Channel tag.** `chan_in` travels down the pipeline alongside the data and emerges as `chan_out`.
- **Throughput.** The pipeline is fully pipelined and accepts `nd` on every cycle, in any channel order.
- **Reset.** `rst` asserted, including mid-operation, has these effects:
  - clears both delay lines and all pipeline registers and valid bits;
  - forces `rdy`=0, `dout`=0, `chan_out`=0;
  - discards any results in flight, so no `rdy` is produced for them.

## Timing
- **Pipeline stages**, where edge 1 is the first rising edge with `nd`=1:
  - edge 1: delay-line shift;
  - edge 2: pre-add;
  - edge 3: multiply;
  - edges 4–8: tree levels 16, 8, 4, 2, 1;
  - edge 9: shift/saturate into the `dout` register, with `rdy`=1.
- **Latency.** `rdy` rises 9 clocks after the `nd` edge and lasts one cycle per accepted sample.
- **Output hold.** `dout` and `chan_out` hold their value until the next `rdy`.
- **Reset behaviour.** `rst` acts asynchronously. The first `nd` sampled after `rst` falls is processed normally.
- **Tap order.** Tap order is defined by `nd` count per channel, not by clock count.

## Test plan
- **Reset.** Pulse `rst` mid-stream → `rdy`/`dout`/`chan_out` go to 0 immediately and no `rdy` occurs for the in-flight samples. Then 63 samples of 1000 on channel B → `dout` matches a fresh filter, with no residue.
- **Step (default COEFS).** Channel B, nd every 64 clocks, din=1000 constant → output n (n=1..63) is floor(1000·512·n / 32768); the 63rd and later outputs are 984. `rdy` comes 9 clocks after each `nd`, with `chan_out`=0.
- **Impulse.** One sample 16'h7FFF, then zeros → 63 outputs of 511, then 0. With asymmetric-valued COEFS, outputs follow h[0..31, 30..0] scaled, confirming tap symmetry.
- **Saturation.** COEFS all 16'h7FFF, din=16'h7FFF constant → `dout` clamps to 131071. With din=16'h8000 constant → `dout` = −131072.
- **Channel isolation.** Interleave channel A (din=1000) and channel B (din=−1000) → A outputs converge to 984 with `chan_out`=1, and B outputs to −985 (floor) with `chan_out`=0. Neither delay line is corrupted by the other.
- **Back-to-back.** `nd` on consecutive cycles for 70 samples → 70 `rdy` pulses on consecutive cycles, each matching a golden model.

Source files
------------

// File: rtl/rx_fir_filter.sv
// Two-channel, 63-tap symmetric linear-phase receive FIR.
// Pipeline: delay-line shift, pre-add, multiply, 5-level adder tree, shift/saturate.
module rx_fir_filter #(
  parameter logic [511:0] COEFS     = {32{16'sd512}},
  parameter int           OUT_SHIFT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               nd,
  input  logic signed [15:0] din,
  input  logic               chan_in,
  output logic               rdy,
  output logic signed [17:0] dout,
  output logic               chan_out
);

  localparam int NTAPS = 63;
  localparam int NUNIQ = 32;
  localparam logic signed [37:0] SAT_MAX = 38'sd131071;
  localparam logic signed [37:0] SAT_MIN = -38'sd131072;

  function automatic logic signed [15:0] coef(input int k);
    return COEFS[16*k +: 16];
  endfunction

  logic signed [15:0] line_a_q [NTAPS];
  logic signed [15:0] line_b_q [NTAPS];
  logic signed [15:0] x_d      [NTAPS];
  logic signed [16:0] s_q      [NUNIQ];
  logic signed [32:0] p_q      [NUNIQ];
  logic signed [33:0] l1_q     [16];
  logic signed [34:0] l2_q     [8];
  logic signed [35:0] l3_q     [4];
  logic signed [36:0] l4_q     [2];
  logic signed [37:0] sum_q;
  logic signed [37:0] y_d;
  logic signed [17:0] dout_d;
  logic [7:0]         vld_q;
  logic [7:0]         chn_q;
  logic               rdy_q;
  logic signed [17:0] dout_q;
  logic               chan_out_q;

  // NOTE: the delay lines are plain register arrays, not RAM, so they can and
  // must be cleared by the async reset; otherwise old taps leak into new output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NTAPS; j++) begin
        line_a_q[j] <= '0;
        line_b_q[j] <= '0;
      end
    end else if (nd) begin
      // NOTE: non-blocking assignment makes every tap read the pre-shift value,
      // so the loop order does not matter.
      if (chan_in) begin
        line_a_q[0] <= din;
        for (int j = 1; j < NTAPS; j++) line_a_q[j] <= line_a_q[j-1];
      end else begin
        line_b_q[0] <= din;
        for (int j = 1; j < NTAPS; j++) line_b_q[j] <= line_b_q[j-1];
      end
    end
  end

  // Valid and channel tag travel alongside the data, one bit per stage 1..8.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      chn_q <= '0;
    end else begin
      vld_q <= {vld_q[6:0], nd};
      chn_q <= {chn_q[6:0], chan_in};
    end
  end

  // NOTE: every element is assigned on every pass, so no latch is inferred.
  always_comb begin
    for (int j = 0; j < NTAPS; j++) x_d[j] = chn_q[0] ? line_a_q[j] : line_b_q[j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUNIQ; k++) begin
        s_q[k] <= '0;
        p_q[k] <= '0;
      end
      for (int i = 0; i < 16; i++) l1_q[i] <= '0;
      for (int i = 0; i < 8; i++)  l2_q[i] <= '0;
      for (int i = 0; i < 4; i++)  l3_q[i] <= '0;
      for (int i = 0; i < 2; i++)  l4_q[i] <= '0;
      sum_q <= '0;
    end else begin
      for (int k = 0; k < NUNIQ - 1; k++) s_q[k] <= 17'(x_d[k]) + 17'(x_d[NTAPS-1-k]);
      s_q[NUNIQ-1] <= 17'(x_d[NUNIQ-1]);
      for (int k = 0; k < NUNIQ; k++) p_q[k] <= 33'(s_q[k]) * 33'(coef(k));
      for (int i = 0; i < 16; i++) l1_q[i] <= 34'(p_q[2*i])  + 34'(p_q[2*i+1]);
      for (int i = 0; i < 8; i++)  l2_q[i] <= 35'(l1_q[2*i]) + 35'(l1_q[2*i+1]);
      for (int i = 0; i < 4; i++)  l3_q[i] <= 36'(l2_q[2*i]) + 36'(l2_q[2*i+1]);
      for (int i = 0; i < 2; i++)  l4_q[i] <= 37'(l3_q[2*i]) + 37'(l3_q[2*i+1]);
      sum_q <= 38'(l4_q[0]) + 38'(l4_q[1]);
    end
  end

  assign y_d = sum_q >>> OUT_SHIFT;

  always_comb begin
    dout_d = y_d[17:0];
    if (y_d > SAT_MAX)      dout_d = 18'sd131071;
    else if (y_d < SAT_MIN) dout_d = -18'sd131072;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q      <= 1'b0;
      dout_q     <= '0;
      chan_out_q <= 1'b0;
    end else begin
      rdy_q <= vld_q[7];
      if (vld_q[7]) begin
        dout_q     <= dout_d;
        chan_out_q <= chn_q[7];
      end
    end
  end

  assign rdy      = rdy_q;
  assign dout     = dout_q;
  assign chan_out = chan_out_q;

endmodule

// File: tb/tb_rx_fir_filter.sv
// Directed bench for rx_fir_filter: three instances (default, ramp and full-scale
// coefficients) share stimulus; one is observed per step.
module tb_rx_fir_filter;

  function automatic logic [511:0] build_asym();
    logic [511:0] v;
    v = '0;
    for (int k = 0; k < 32; k++) v[16*k +: 16] = 16'(256 * (k + 1));
    return v;
  endfunction

  localparam logic [511:0] ASYM_COEFS = build_asym();
  localparam logic [511:0] MAX_COEFS  = {32{16'h7FFF}};

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               nd = 1'b0;
  logic               chan_in = 1'b0;
  logic signed [15:0] din = '0;

  logic               rdy_w  [3];
  logic signed [17:0] dout_w [3];
  logic               chan_w [3];

  rx_fir_filter u_dflt (
    .clk(clk), .rst(rst), .nd(nd), .din(din), .chan_in(chan_in),
    .rdy(rdy_w[0]), .dout(dout_w[0]), .chan_out(chan_w[0])
  );

  rx_fir_filter #(.COEFS(ASYM_COEFS)) u_asym (
    .clk(clk), .rst(rst), .nd(nd), .din(din), .chan_in(chan_in),
    .rdy(rdy_w[1]), .dout(dout_w[1]), .chan_out(chan_w[1])
  );

  rx_fir_filter #(.COEFS(MAX_COEFS)) u_max (
    .clk(clk), .rst(rst), .nd(nd), .din(din), .chan_in(chan_in),
    .rdy(rdy_w[2]), .dout(dout_w[2]), .chan_out(chan_w[2])
  );

  always #5 clk = ~clk;

  int                 checks = 0;
  int                 errors = 0;
  int                 cur_sel = 0;
  int                 din_v  [128];
  logic               chan_v [128];
  int                 exp_v  [128];
  logic               obs_rdy;
  logic signed [17:0] obs_dout;
  logic               obs_chan;

  always_comb begin
    obs_rdy  = rdy_w[cur_sel];
    obs_dout = dout_w[cur_sel];
    obs_chan = chan_w[cur_sel];
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int h_of(input int sel, input int k);
    case (sel)
      0:       return 512;
      1:       return 256 * (k + 1);
      default: return 32767;
    endcase
  endfunction

  // Direct-form convolution over the full 63-tap history of one channel.
  function automatic int model(input int hist [63], input int sel);
    longint acc = 0;
    for (int j = 0; j < 63; j++)
      acc += longint'(hist[j]) * longint'(h_of(sel, (j <= 31) ? j : 62 - j));
    acc = acc >>> 15;
    if (acc > 131071)  acc = 131071;
    if (acc < -131072) acc = -131072;
    return int'(acc);
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    nd  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Sample i is driven at loop cycle i*gap; its result must appear at cycle i*gap+9.
  task automatic run(input int n, input int gap, input int sel, input string tag);
    int   k;
    int   idx;
    logic exp_rdy;
    logic have = 1'b0;
    int   last_d = 0;
    logic last_c = 1'b0;
    cur_sel = sel;
    for (int c = 0; c < n * gap + 12; c++) begin
      @(negedge clk);
      k = c - 9;
      exp_rdy = (k >= 0) && (k % gap == 0) && (k / gap < n);
      check($sformatf("%s c%0d rdy", tag, c), 64'(obs_rdy), 64'(exp_rdy));
      if (exp_rdy) begin
        idx = k / gap;
        check($sformatf("%s[%0d] dout", tag, idx), 64'(obs_dout), 64'(exp_v[idx]));
        check($sformatf("%s[%0d] chan", tag, idx), 64'(obs_chan), 64'(chan_v[idx]));
        have   = 1'b1;
        last_d = exp_v[idx];
        last_c = chan_v[idx];
      end else if (have) begin
        check($sformatf("%s c%0d hold dout", tag, c), 64'(obs_dout), 64'(last_d));
        check($sformatf("%s c%0d hold chan", tag, c), 64'(obs_chan), 64'(last_c));
      end
      if ((c % gap == 0) && (c / gap < n)) begin
        nd      = 1'b1;
        din     = 16'(din_v[c / gap]);
        chan_in = chan_v[c / gap];
      end else begin
        nd = 1'b0;
      end
    end
    nd = 1'b0;
  endtask

  initial begin
    int hist_a [63];
    int hist_b [63];
    int cnt;
    int m_a;
    int m_b;

    // Reset state on every instance.
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      cur_sel = s;
      #1;
      check($sformatf("reset rdy%0d", s), 64'(obs_rdy), 64'(0));
      check($sformatf("reset dout%0d", s), 64'(obs_dout), 64'(0));
      check($sformatf("reset chan%0d", s), 64'(obs_chan), 64'(0));
    end
    rst = 1'b0;

    // Step, channel B, one sample per 64 clocks: n-th output = floor(512000*n/32768).
    reset_dut();
    for (int i = 0; i < 64; i++) begin
      din_v[i]  = 1000;
      chan_v[i] = 1'b0;
      exp_v[i]  = (512000 * ((i < 63) ? i + 1 : 63)) >>> 15;
    end
    run(64, 64, 0, "step");

    // Impulse, default coefficients: 63 outputs of 511 then zeros.
    reset_dut();
    for (int i = 0; i < 70; i++) begin
      din_v[i]  = (i == 0) ? 32767 : 0;
      chan_v[i] = 1'b0;
      exp_v[i]  = (i < 63) ? 511 : 0;
    end
    run(70, 1, 0, "imp_dflt");

    // Impulse, ramp coefficients h[k]=256(k+1): output j = 256*(min(j,62-j)+1)-1.
    reset_dut();
    for (int i = 0; i < 70; i++)
      exp_v[i] = (i < 63) ? 256 * (((i <= 31) ? i : 62 - i) + 1) - 1 : 0;
    run(70, 1, 1, "imp_asym");

    // Saturation high: 32766*n until clamped at 131071.
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      din_v[i]  = 32767;
      chan_v[i] = 1'b1;
      exp_v[i]  = (32766 * (i + 1) > 131071) ? 131071 : 32766 * (i + 1);
    end
    run(10, 1, 2, "sat_hi");

    // Saturation low: -32767*n until clamped at -131072.
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      din_v[i] = -32768;
      exp_v[i] = (-32767 * (i + 1) < -131072) ? -131072 : -32767 * (i + 1);
    end
    run(10, 1, 2, "sat_lo");

    // Channel isolation: interleaved A=+1000 and B=-1000, each a clean step.
    reset_dut();
    m_a = 0;
    m_b = 0;
    for (int i = 0; i < 128; i++) begin
      chan_v[i] = (i % 2 == 0);
      if (chan_v[i]) begin
        m_a++;
        din_v[i] = 1000;
        exp_v[i] = (512000 * ((m_a < 63) ? m_a : 63)) >>> 15;
      end else begin
        m_b++;
        din_v[i] = -1000;
        exp_v[i] = (-512000 * ((m_b < 63) ? m_b : 63)) >>> 15;
      end
    end
    run(128, 1, 0, "iso");

    // Back-to-back random samples on random channels against the convolution model.
    reset_dut();
    for (int j = 0; j < 63; j++) begin
      hist_a[j] = 0;
      hist_b[j] = 0;
    end
    for (int i = 0; i < 70; i++) begin
      din_v[i]  = int'($urandom_range(0, 65535)) - 32768;
      chan_v[i] = 1'($urandom_range(0, 1));
      if (chan_v[i]) begin
        for (int j = 62; j > 0; j--) hist_a[j] = hist_a[j-1];
        hist_a[0] = din_v[i];
        exp_v[i]  = model(hist_a, 0);
      end else begin
        for (int j = 62; j > 0; j--) hist_b[j] = hist_b[j-1];
        hist_b[0] = din_v[i];
        exp_v[i]  = model(hist_b, 0);
      end
    end
    run(70, 1, 0, "b2b");

    // Mid-stream reset: outputs clear at once, in-flight results vanish, no residue.
    reset_dut();
    cur_sel = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      nd      = 1'b1;
      din     = 16'sd1000;
      chan_in = i[0];
    end
    check("midrst pre rdy", 64'(obs_rdy), 64'(1));
    check("midrst pre dout nonzero", 64'(obs_dout != 0), 64'(1));
    nd = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst rdy", 64'(obs_rdy), 64'(0));
    check("midrst dout", 64'(obs_dout), 64'(0));
    check("midrst chan", 64'(obs_chan), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (obs_rdy) cnt++;
    end
    check("midrst flushed rdy count", 64'(cnt), 64'(0));
    for (int i = 0; i < 63; i++) begin
      din_v[i]  = 1000;
      chan_v[i] = 1'b0;
      exp_v[i]  = (512000 * (i + 1)) >>> 15;
    end
    run(63, 1, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
